// File: rtl/wb_regfile.sv
// Write-back stage register file: selects load/ALU result, commits to the integer array,
// serves two async read ports and counts committed writes. Optional macro: WB_REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wb_ctrl,
    input  logic [XLEN-1:0]   wb_read_data,
    input  logic [XLEN-1:0]   wb_alu_res,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic [XLEN-1:0]   wb_write_data,
    output logic [XLEN-1:0]   wb_retire_count
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] count_q;
    logic            commit;
    logic            rd_in_range;

    assign wb_write_data   = wb_ctrl[0] ? wb_read_data : wb_alu_res;
    assign rd_in_range     = (32'(wb_rd) < NREGS);
    assign commit          = wb_ctrl[1] && (wb_rd != '0) && rd_in_range && !rst;
    assign wb_retire_count = count_q;

    // x0, out-of-range and reset forcing take priority over everything, including bypass.
    function automatic logic [XLEN-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        if (!rst && (addr != '0) && (32'(addr) < NREGS)) begin
`ifdef WB_REGFILE_BYPASS_EN
            if (commit && (addr == wb_rd)) begin
                val = wb_write_data;
            end else begin
                val = regs_q[addr];
            end
`else
            val = regs_q[addr];
`endif
        end
        return val;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else if (commit) begin
            regs_q[wb_rd] <= wb_write_data;
            count_q       <= count_q + XLEN'(1);
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: a full-size instance plus a narrow,
// short instance (XLEN=4, NREGS=20) for counter wrap and out-of-range addresses.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [1:0]  wb_ctrl;
    logic [63:0] wb_read_data;
    logic [63:0] wb_alu_res;
    logic [4:0]  wb_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] wb_write_data;
    logic [63:0] wb_retire_count;

    logic        s_rst;
    logic [1:0]  s_ctrl;
    logic [3:0]  s_read_data;
    logic [3:0]  s_alu_res;
    logic [4:0]  s_rd;
    logic [4:0]  s_rs1_addr;
    logic [4:0]  s_rs2_addr;
    logic [3:0]  s_rs1_data;
    logic [3:0]  s_rs2_data;
    logic [3:0]  s_write_data;
    logic [3:0]  s_retire_count;

    int unsigned n_checks;
    int unsigned n_fails;

    wb_regfile dut (
        .clk             (clk),
        .rst             (rst),
        .wb_ctrl         (wb_ctrl),
        .wb_read_data    (wb_read_data),
        .wb_alu_res      (wb_alu_res),
        .wb_rd           (wb_rd),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .wb_write_data   (wb_write_data),
        .wb_retire_count (wb_retire_count)
    );

    wb_regfile #(
        .XLEN   (4),
        .NREGS  (20),
        .ADDR_W (5)
    ) dut_small (
        .clk             (clk),
        .rst             (s_rst),
        .wb_ctrl         (s_ctrl),
        .wb_read_data    (s_read_data),
        .wb_alu_res      (s_alu_res),
        .wb_rd           (s_rd),
        .rs1_addr        (s_rs1_addr),
        .rs2_addr        (s_rs2_addr),
        .rs1_data        (s_rs1_data),
        .rs2_data        (s_rs2_data),
        .wb_write_data   (s_write_data),
        .wb_retire_count (s_retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        rst          = 1'b1;
        wb_ctrl      = 2'b00;
        wb_read_data = '0;
        wb_alu_res   = '0;
        wb_rd        = '0;
        rs1_addr     = 5'd5;
        rs2_addr     = '0;
        s_rst        = 1'b1;
        s_ctrl       = 2'b00;
        s_read_data  = '0;
        s_alu_res    = '0;
        s_rd         = '0;
        s_rs1_addr   = '0;
        s_rs2_addr   = '0;

        // Reset held for two edges; reads forced to zero while asserted.
        tick();
        tick();
        check("rst_force_rs1", rs1_data, 64'h0);
        rst   = 1'b0;
        s_rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            check($sformatf("reset_rs1_x%0d", a), rs1_data, 64'h0);
            check($sformatf("reset_rs2_x%0d", 31 - a), rs2_data, 64'h0);
        end
        check("reset_count", wb_retire_count, 64'h0);

        // ALU write-back to x5.
        wb_ctrl      = 2'b10;
        wb_alu_res   = 64'hDEAD_BEEF_0000_0001;
        wb_read_data = 64'h0000_0000_0000_0777;
        wb_rd        = 5'd5;
        #1;
        check("wdata_alu_sel", wb_write_data, 64'hDEAD_BEEF_0000_0001);
        tick();
        wb_ctrl  = 2'b00;
        rs1_addr = 5'd5;
        #1;
        check("alu_write_x5", rs1_data, 64'hDEAD_BEEF_0000_0001);
        check("alu_write_count", wb_retire_count, 64'd1);

        // Load write-back to x7.
        wb_ctrl      = 2'b11;
        wb_read_data = 64'h1234;
        wb_alu_res   = 64'h99;
        wb_rd        = 5'd7;
        #1;
        check("wdata_load_sel", wb_write_data, 64'h1234);
        tick();
        wb_ctrl  = 2'b00;
        rs2_addr = 5'd7;
        #1;
        check("load_write_x7", rs2_data, 64'h1234);
        check("load_write_count", wb_retire_count, 64'd2);

        // Write to x0 is discarded and not counted.
        wb_ctrl      = 2'b11;
        wb_read_data = 64'hFFFF;
        wb_rd        = 5'd0;
        tick();
        wb_ctrl  = 2'b00;
        rs2_addr = 5'd0;
        #1;
        check("x0_read_zero", rs2_data, 64'h0);
        check("x0_write_count", wb_retire_count, 64'd2);

        // RegWrite low: no write, no count, but the mux output is still valid.
        wb_ctrl      = 2'b00;
        wb_rd        = 5'd4;
        wb_alu_res   = 64'h55;
        wb_read_data = 64'h66;
        #1;
        check("wdata_regwrite_low", wb_write_data, 64'h55);
        tick();
        rs1_addr = 5'd4;
        #1;
        check("regwrite_low_x4", rs1_data, 64'h0);
        check("regwrite_low_count", wb_retire_count, 64'd2);

        // Same-cycle write/read of x9.
        wb_ctrl    = 2'b10;
        wb_rd      = 5'd9;
        wb_alu_res = 64'h1;
        tick();
        wb_alu_res = 64'h2;
        rs1_addr   = 5'd9;
        rs2_addr   = 5'd0;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        check("hazard_same_cycle", rs1_data, 64'h2);
`else
        check("hazard_same_cycle", rs1_data, 64'h1);
`endif
        check("hazard_x0_priority", rs2_data, 64'h0);
        tick();
        wb_ctrl = 2'b00;
        #1;
        check("hazard_next_cycle", rs1_data, 64'h2);
        check("hazard_count", wb_retire_count, 64'd4);

        // Reset on the same edge as a commit: write dropped, reads forced to zero.
        rst        = 1'b1;
        wb_ctrl    = 2'b10;
        wb_rd      = 5'd3;
        wb_alu_res = 64'hAA;
        rs1_addr   = 5'd3;
        rs2_addr   = 5'd9;
        #1;
        check("rst_over_bypass", rs1_data, 64'h0);
        check("rst_force_rs2", rs2_data, 64'h0);
        tick();
        rst     = 1'b0;
        wb_ctrl = 2'b00;
        #1;
        check("rst_mid_write_x3", rs1_data, 64'h0);
        check("rst_clears_x9", rs2_data, 64'h0);
        check("rst_mid_write_count", wb_retire_count, 64'd0);

        // Narrow instance: 16 commits wrap a 4-bit counter back to zero.
        s_ctrl = 2'b10;
        s_rd   = 5'd1;
        for (int i = 0; i < 15; i++) begin
            s_alu_res = 4'(i);
            tick();
        end
        check("small_count_max", 64'(s_retire_count), 64'hF);
        s_alu_res = 4'hF;
        tick();
        check("small_count_wrap", 64'(s_retire_count), 64'h0);

        // Out-of-range write is discarded and not counted; read returns zero.
        s_rd      = 5'd25;
        s_alu_res = 4'h7;
        tick();
        s_ctrl     = 2'b00;
        s_rs1_addr = 5'd25;
        s_rs2_addr = 5'd1;
        #1;
        check("oor_read_zero", 64'(s_rs1_data), 64'h0);
        check("oor_write_count", 64'(s_retire_count), 64'h0);
        check("small_x1_last", 64'(s_rs2_data), 64'hF);

        // Highest in-range register still writes and counts.
        s_ctrl    = 2'b10;
        s_rd      = 5'd19;
        s_alu_res = 4'h5;
        tick();
        s_ctrl     = 2'b00;
        s_rs1_addr = 5'd19;
        #1;
        check("top_reg_x19", 64'(s_rs1_data), 64'h5);
        check("top_reg_count", 64'(s_retire_count), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
